pontuacao_scanner: RTL and testbench

Score-calculation master for the memory controller's pontuacao read port. On a start pulse it streams all 32 rows of one player's board through the controller's read path. It counts intact-ship, hit and miss cells, then publishes registered totals plus a defeat flag for the game FSM and the display. Read-only: it never writes board memory.

---
 rtl/pontuacao_scanner.sv | 191 +++++++++++++++++++
 tb/tb_pontuacao_scanner.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pontuacao_scanner.sv
// pontuacao_scanner: read-only board scorer. Streams the 32 rows of one
// player's board through the controller's pontuacao read port, counts intact,
// hit and water-shot cells, and publishes registered totals with a done pulse.
module pontuacao_scanner #(
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        resetGeral,
    input  logic        start,
    input  logic        jogador,
    input  logic        grant,
    input  logic [63:0] dataReadPontuacao,
    output logic        readyPontuacao,
    output logic [4:0]  pontuacao_addr,
    output logic        jogadorPontuacao,
    output logic        busy,
    output logic        done,
    output logic [10:0] navios,
    output logic [10:0] acertos,
    output logic [10:0] erros,
    output logic        derrota
);

    localparam logic [4:0] LastRow = 5'd31;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain,
        StDone
    } state_e;

    // Number of 2-bit cells in a row equal to the given code (0..32).
    function automatic logic [5:0] count_code(input logic [63:0] row, input logic [1:0] code);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            if (row[2*i +: 2] == code) begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    state_e              state_q, state_d;
    logic [4:0]          req_addr_q, req_addr_d;
    logic [4:0]          cap_addr_q, cap_addr_d;
    // One valid tag per granted request; the oldest bit marks a returning row.
    logic [READ_LAT-1:0] tag_q, tag_d;
    logic [10:0]         acc_nav_q, acc_nav_d;
    logic [10:0]         acc_hit_q, acc_hit_d;
    logic [10:0]         acc_err_q, acc_err_d;
    logic                jog_q, jog_d;
    logic [10:0]         nav_q, hit_q, err_q;
    logic                derrota_q;

    logic [5:0]          row_nav, row_hit, row_err;
    logic                push;
    logic                capture;
    logic                publish;

    // Per-row cell counts of the data currently on the read bus.
    always_comb begin
        row_nav = count_code(dataReadPontuacao, 2'b01);
        row_hit = count_code(dataReadPontuacao, 2'b10);
        row_err = count_code(dataReadPontuacao, 2'b11);
    end

    // Next-state logic: request issue, tag pipeline, capture and grant-loss recovery.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        cap_addr_d = cap_addr_q;
        tag_d      = tag_q;
        acc_nav_d  = acc_nav_q;
        acc_hit_d  = acc_hit_q;
        acc_err_d  = acc_err_q;
        jog_d      = jog_q;
        push       = 1'b0;
        capture    = 1'b0;
        publish    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StReq;
                    req_addr_d = '0;
                    cap_addr_d = '0;
                    tag_d      = '0;
                    acc_nav_d  = '0;
                    acc_hit_d  = '0;
                    acc_err_d  = '0;
                    jog_d      = jogador;
                end
            end
            StReq, StDrain: begin
                if (!grant) begin
                    // In-flight reads are lost: restart from the first uncaptured row.
                    tag_d      = '0;
                    req_addr_d = cap_addr_q;
                    state_d    = StReq;
                end else begin
                    capture  = tag_q[READ_LAT-1];
                    push     = (state_q == StReq);
                    tag_d    = tag_q << 1;
                    tag_d[0] = push;
                    if (capture) begin
                        acc_nav_d  = acc_nav_q + {5'd0, row_nav};
                        acc_hit_d  = acc_hit_q + {5'd0, row_hit};
                        acc_err_d  = acc_err_q + {5'd0, row_err};
                        cap_addr_d = cap_addr_q + 5'd1;
                    end
                    if (state_q == StReq) begin
                        req_addr_d = req_addr_q + 5'd1;
                        if (req_addr_q == LastRow) begin
                            state_d = StDrain;
                        end
                    end else if (capture && (cap_addr_q == LastRow)) begin
                        // Last row lands now; totals are loaded so they are valid with done.
                        state_d = StDone;
                        publish = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            cap_addr_q <= '0;
            tag_q      <= '0;
            acc_nav_q  <= '0;
            acc_hit_q  <= '0;
            acc_err_q  <= '0;
            jog_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cap_addr_q <= cap_addr_d;
            tag_q      <= tag_d;
            acc_nav_q  <= acc_nav_d;
            acc_hit_q  <= acc_hit_d;
            acc_err_q  <= acc_err_d;
            jog_q      <= jog_d;
        end
    end

    // Published totals: hold until a scan completes.
    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            nav_q     <= '0;
            hit_q     <= '0;
            err_q     <= '0;
            derrota_q <= 1'b0;
        end else if (publish) begin
            nav_q     <= acc_nav_d;
            hit_q     <= acc_hit_d;
            err_q     <= acc_err_d;
            derrota_q <= (acc_nav_d == 11'd0) && (acc_hit_d != 11'd0);
        end
    end

    // Port outputs decoded from the state register.
    always_comb begin
        readyPontuacao = (state_q == StReq) || (state_q == StDrain);
        busy           = (state_q != StIdle);
        done           = (state_q == StDone);
        pontuacao_addr = '0;
        if (state_q == StReq) begin
            pontuacao_addr = req_addr_q;
        end else if (state_q == StDrain) begin
            pontuacao_addr = LastRow;
        end
    end

    assign jogadorPontuacao = jog_q;
    assign navios           = nav_q;
    assign acertos          = hit_q;
    assign erros            = err_q;
    assign derrota          = derrota_q;

endmodule

// File: tb/tb_pontuacao_scanner.sv
// Bench for pontuacao_scanner: a board-memory/controller model with a fixed
// read latency, a totals model computed straight from the board contents, and
// one compare process running on every falling edge.
module tb_pontuacao_scanner;

    localparam int unsigned RL = 2;

    typedef struct packed {
        logic [10:0] nav;
        logic [10:0] hit;
        logic [10:0] err;
        logic        der;
    } totals_t;

    logic        clk = 1'b0;
    logic        resetGeral;
    logic        start;
    logic        jogador;
    logic        grant;
    logic [63:0] dataReadPontuacao;
    logic        readyPontuacao;
    logic [4:0]  pontuacao_addr;
    logic        jogadorPontuacao;
    logic        busy;
    logic        done;
    logic [10:0] navios, acertos, erros;
    logic        derrota;

    pontuacao_scanner #(.READ_LAT(RL)) dut (
        .clk               (clk),
        .resetGeral        (resetGeral),
        .start             (start),
        .jogador           (jogador),
        .grant             (grant),
        .dataReadPontuacao (dataReadPontuacao),
        .readyPontuacao    (readyPontuacao),
        .pontuacao_addr    (pontuacao_addr),
        .jogadorPontuacao  (jogadorPontuacao),
        .busy              (busy),
        .done              (done),
        .navios            (navios),
        .acertos           (acertos),
        .erros             (erros),
        .derrota           (derrota)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- controller / board memory model ----------------
    logic [63:0] mem [2][32];
    logic [4:0]  pa [RL];
    logic        pv [RL];
    logic [63:0] junk;

    always @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            for (int i = 0; i < RL; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
            junk <= '0;
        end else begin
            pv[0] <= readyPontuacao && grant;
            pa[0] <= pontuacao_addr;
            for (int i = 1; i < RL; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            junk <= {$urandom, $urandom};
        end
    end

    // Row data only meaningful when a granted read matures; otherwise garbage.
    assign dataReadPontuacao = (pv[RL-1] && grant) ? mem[jogadorPontuacao][pa[RL-1]] : junk;

    // ---------------- totals model ----------------
    function automatic totals_t board_totals(input logic p);
        int n, h, e;
        totals_t t;
        n = 0; h = 0; e = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                case (mem[p][r][2*c +: 2])
                    2'b01:   n++;
                    2'b10:   h++;
                    2'b11:   e++;
                    default: ;
                endcase
            end
        end
        t.nav = 11'(n);
        t.hit = 11'(h);
        t.err = 11'(e);
        t.der = (n == 0) && (h > 0);
        return t;
    endfunction

    logic    m_busy;
    logic    m_jog;
    totals_t m_exp;
    int      m_start;

    always @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            m_busy <= 1'b0;
            m_jog  <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_jog   <= jogador;
                m_exp   <= board_totals(jogador);
                m_start <= cyc;
            end
        end else if (done) begin
            m_busy <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    totals_t pub;
    int      drops, runs, lat_c, lo_c, exp_addr;
    logic    prev_g;
    bit      addr_chk = 0;

    always @(negedge clk) begin
        if (!resetGeral) begin
            chk("reset_ctrl", 64'({readyPontuacao, busy, done, jogadorPontuacao, pontuacao_addr}), 64'd0);
            chk("reset_totals", 64'({navios, acertos, erros, derrota}), 64'd0);
            pub    <= '0;
            drops  <= 0;
            runs   <= 0;
            prev_g <= 1'b1;
        end else begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("jogadorPontuacao", 64'(jogadorPontuacao), 64'(m_jog));
            chk("readyPontuacao", 64'(readyPontuacao), 64'(m_busy && !done));
            chk("spurious_done", 64'(done && !m_busy), 64'd0);
            if (done && m_busy) begin
                chk("totals_at_done", 64'({navios, acertos, erros, derrota}), 64'(m_exp));
                lat_c = cyc - m_start;
                lo_c  = 33 + RL + drops;
                if (runs == 0) chk("latency", 64'(lat_c), 64'(lo_c));
                else chk("latency_range", 64'((lat_c >= lo_c) && (lat_c <= lo_c + RL * runs)), 64'd1);
                pub    <= m_exp;
                drops  <= 0;
                runs   <= 0;
                prev_g <= 1'b1;
            end else begin
                chk("totals_hold", 64'({navios, acertos, erros, derrota}), 64'(pub));
                if (m_busy) begin
                    if (!grant) begin
                        drops <= drops + 1;
                        if (prev_g) runs <= runs + 1;
                    end
                    prev_g <= grant;
                    if (addr_chk) begin
                        exp_addr = cyc - m_start - 1;
                        if (exp_addr > 31) exp_addr = 31;
                        chk("addr", 64'(pontuacao_addr), 64'(exp_addr));
                    end
                end
            end
        end
    end

    // ---------------- grant driver ----------------
    int gmode = 0;
    int dstart = 0;
    int dend = 0;

    initial begin
        grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (gmode)
                1:       grant = !((cyc >= dstart) && (cyc < dend));
                2:       grant = ($urandom_range(5) != 0);
                default: grant = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_scan(input logic p);
        @(posedge clk);
        #1;
        start   = 1'b1;
        jogador = p;
        @(posedge clk);
        #1;
        start   = 1'b0;
        jogador = 1'($urandom);
    endtask

    // Wait for done (bounded); optionally fire stray start pulses meanwhile.
    task automatic wait_done(input int budget, input bit poke, output int lat);
        bit found;
        found = 0;
        lat = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk);
            #1;
            if (poke) begin
                start   = ($urandom_range(9) == 0);
                jogador = 1'($urandom);
            end
            @(negedge clk);
            if (done) begin
                found = 1;
                lat = cyc - m_start;
            end
        end
        start = 1'b0;
        if (!found) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_rel(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < m_start + n);
    endtask

    task automatic rand_board(input logic p, input bit no_ships);
        logic [1:0] code;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                code = 2'($urandom_range(3));
                if (no_ships && code == 2'b01) code = 2'b11;
                mem[p][r][2*c +: 2] = code;
            end
        end
    endtask

    int      lat;
    totals_t saved;

    initial begin
        resetGeral = 1'b0;
        start      = 1'b0;
        jogador    = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 32; r++) mem[p][r] = '0;
        repeat (3) @(negedge clk);
        #2 resetGeral = 1'b1;
        repeat (2) @(negedge clk);

        // Empty board, player 1.
        addr_chk = 1;
        start_scan(1'b0);
        wait_done(100, 0, lat);
        chk("empty_done_cycle", 64'(lat), 64'd35);
        chk("empty_totals", 64'({navios, acertos, erros, derrota}), 64'd0);

        // 17 intact in row 0, 3 hits in row 31, player 2.
        rand_board(1'b0, 0);
        for (int c = 0; c < 17; c++) mem[1][0][2*c +: 2] = 2'b01;
        for (int c = 0; c < 3; c++) mem[1][31][2*c +: 2] = 2'b10;
        start_scan(1'b1);
        wait_done(100, 0, lat);
        chk("p2_jogador", 64'(jogadorPontuacao), 64'd1);
        chk("p2_navios", 64'(navios), 64'd17);
        chk("p2_acertos", 64'(acertos), 64'd3);
        chk("p2_erros_derrota", 64'({erros, derrota}), 64'd0);

        // Alternating all-hit / all-shot rows: defeat.
        for (int r = 0; r < 32; r++) mem[0][r] = (r % 2 == 0) ? {32{2'b10}} : {32{2'b11}};
        start_scan(1'b0);
        wait_done(100, 0, lat);
        chk("alt_done_cycle", 64'(lat), 64'd35);
        chk("alt_acertos", 64'(acertos), 64'd512);
        chk("alt_erros", 64'(erros), 64'd512);
        chk("alt_navios_derrota", 64'({navios, derrota}), 64'd1);
        addr_chk = 0;

        // Distinct count per row; reference run, then a 5-cycle grant drop at addr 10.
        for (int r = 0; r < 32; r++) begin
            mem[1][r] = '0;
            for (int c = 0; c <= r; c++) mem[1][r][2*c +: 2] = 2'b01;
            if (r < 31 && r % 2 == 1) mem[1][r][63:62] = 2'b11;
        end
        start_scan(1'b1);
        wait_done(100, 0, lat);
        chk("distinct_navios", 64'(navios), 64'd528);
        chk("distinct_erros", 64'(erros), 64'd15);
        saved = totals_t'({navios, acertos, erros, derrota});
        dstart = 0;
        dend   = 0;
        gmode  = 1;
        start_scan(1'b1);
        dstart = m_start + 11;
        dend   = dstart + 5;
        wait_done(200, 0, lat);
        gmode = 0;
        chk("drop_done_cycle", 64'(lat), 64'd42);
        chk("drop_totals_match", 64'({navios, acertos, erros, derrota}), 64'(saved));

        // Second start at cycle 20 with jogador toggled: ignored.
        rand_board(1'b0, 0);
        rand_board(1'b1, 0);
        start_scan(1'b0);
        wait_rel(20);
        start   = 1'b1;
        jogador = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100, 0, lat);
        chk("restart_done_cycle", 64'(lat), 64'd35);
        chk("restart_jogador", 64'(jogadorPontuacao), 64'd0);
        repeat (40) @(negedge clk);

        // Reset in the middle of a scan.
        start_scan(1'b1);
        wait_rel(15);
        resetGeral = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({readyPontuacao, busy, done, jogadorPontuacao, pontuacao_addr}),
            64'd0);
        chk("async_reset_totals", 64'({navios, acertos, erros, derrota}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #2 resetGeral = 1'b1;
        repeat (50) @(negedge clk);
        start_scan(1'b1);
        wait_done(100, 0, lat);
        chk("post_reset_done_cycle", 64'(lat), 64'd35);

        // Randomized boards, grant drops and stray start pulses.
        for (int it = 0; it < 16; it++) begin
            logic p;
            p = 1'($urandom);
            rand_board(p, (it % 4) == 0);
            rand_board(!p, 0);
            gmode = (it % 2 == 1) ? 2 : 0;
            start_scan(p);
            wait_done(600, 1, lat);
            gmode = 0;
            repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
